// File: rtl/lagd_mem_pkg.sv
// Shared types for the memory-island bank adapter.
// Origin tags carried alongside each SRAM access.
package lagd_mem_pkg;

  typedef enum logic {
    MEM_SRC_NARROW = 1'b0,
    MEM_SRC_WIDE   = 1'b1
  } mem_src_e;

  typedef struct packed {
    logic     valid;
    mem_src_e src;
    logic     we;
  } mem_tag_t;

  localparam int unsigned TagWidth = $bits(mem_tag_t);

  function automatic int unsigned row_shift(
    input int unsigned bytes,
    input int unsigned banks
  );
    return $clog2(bytes) + $clog2(banks);
  endfunction

endpackage

// File: rtl/bank_tag_pipe.sv
// Per-bank origin tag delay line matching the SRAM read latency.
// Shifts every cycle; reset drops everything in flight.
module bank_tag_pipe
  import lagd_mem_pkg::*;
#(
  parameter int unsigned SramLatency = 1
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [TagWidth-1:0] tag_i,
  output logic [TagWidth-1:0] tag_o
);

  logic [TagWidth-1:0] stage_q [SramLatency];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int s = 0; s < int'(SramLatency); s++) begin
        stage_q[s] <= '0;
      end
    end else begin
      stage_q[0] <= tag_i;
      for (int s = 1; s < int'(SramLatency); s++) begin
        stage_q[s] <= stage_q[s-1];
      end
    end
  end

  assign tag_o = stage_q[SramLatency-1];

endmodule

// File: rtl/mem_bank_adapter.sv
// Narrow/wide request to SRAM bank adapter with response merge.
// LAGD_MEM_RSP_REG_EN adds a response output register.
module mem_bank_adapter
  import lagd_mem_pkg::*;
#(
  parameter int unsigned NumNarrowBanks  = 16,
  parameter int unsigned NarrowPerWide   = 8,
  parameter int unsigned NarrowDataWidth = 32,
  parameter int unsigned AddrWidth       = 32,
  parameter int unsigned RowAddrWidth    = 10,
  parameter int unsigned SramLatency     = 1,
  localparam int unsigned NumWideBanks   = NumNarrowBanks / NarrowPerWide,
  localparam int unsigned WideDataWidth  = NarrowDataWidth * NarrowPerWide,
  localparam int unsigned NarrowBeWidth  = NarrowDataWidth / 8,
  localparam int unsigned WideBeWidth    = WideDataWidth / 8
) (
  input  logic                                      clk_i,
  input  logic                                      rst_i,
  input  logic [NumNarrowBanks-1:0]                 narrow_req_i,
  input  logic [NumNarrowBanks-1:0]                 narrow_gnt_i,
  input  logic [NumNarrowBanks-1:0]                 narrow_we_i,
  input  logic [NumNarrowBanks*AddrWidth-1:0]       narrow_addr_i,
  input  logic [NumNarrowBanks*NarrowDataWidth-1:0] narrow_wdata_i,
  input  logic [NumNarrowBanks*NarrowBeWidth-1:0]   narrow_be_i,
  input  logic [NumWideBanks-1:0]                   wide_req_i,
  input  logic [NumWideBanks-1:0]                   wide_gnt_i,
  input  logic [NumWideBanks-1:0]                   wide_we_i,
  input  logic [NumWideBanks*AddrWidth-1:0]         wide_addr_i,
  input  logic [NumWideBanks*WideDataWidth-1:0]     wide_wdata_i,
  input  logic [NumWideBanks*WideBeWidth-1:0]       wide_be_i,
  output logic [NumNarrowBanks-1:0]                 bank_req_o,
  output logic [NumNarrowBanks-1:0]                 bank_we_o,
  output logic [NumNarrowBanks*RowAddrWidth-1:0]    bank_addr_o,
  output logic [NumNarrowBanks*NarrowDataWidth-1:0] bank_wdata_o,
  output logic [NumNarrowBanks*NarrowBeWidth-1:0]   bank_be_o,
  input  logic [NumNarrowBanks*NarrowDataWidth-1:0] bank_rdata_i,
  output logic [NumNarrowBanks-1:0]                 narrow_rvalid_o,
  output logic [NumNarrowBanks*NarrowDataWidth-1:0] narrow_rdata_o,
  output logic [NumWideBanks-1:0]                   wide_rvalid_o,
  output logic [NumWideBanks*WideDataWidth-1:0]     wide_rdata_o
);

  localparam int unsigned NarrowShift = row_shift(NarrowBeWidth, NumNarrowBanks);
  localparam int unsigned WideShift   = row_shift(WideBeWidth, NumWideBanks);

  logic [NumNarrowBanks-1:0] nf;
  logic [NumWideBanks-1:0]   wf;
  logic [NumNarrowBanks-1:0] wide_slot;
  mem_tag_t                  tag_in  [NumNarrowBanks];
  mem_tag_t                  tag_out [NumNarrowBanks];

  logic [NumNarrowBanks-1:0]                 n_rvalid_d;
  logic [NumNarrowBanks*NarrowDataWidth-1:0] n_rdata_d;
  logic [NumWideBanks-1:0]                   w_rvalid_d;
  logic [NumWideBanks*WideDataWidth-1:0]     w_rdata_d;

  for (genvar j = 0; j < int'(NumWideBanks); j++) begin : g_wide
    logic [NarrowPerWide-1:0] slots;
    assign wf[j]         = wide_req_i[j] & wide_gnt_i[j] & ~rst_i;
    assign slots         = wide_slot[j*NarrowPerWide +: NarrowPerWide];
    assign w_rvalid_d[j] = &slots;

    a_wide_whole: assert property (@(posedge clk_i) disable iff (rst_i)
      !(|slots) || (&slots));
  end

  for (genvar i = 0; i < int'(NumNarrowBanks); i++) begin : g_bank
    localparam int unsigned G = i / NarrowPerWide;
    localparam int unsigned DW = NarrowDataWidth;
    localparam int unsigned BW = NarrowBeWidth;

    logic [RowAddrWidth-1:0] n_row;
    logic [RowAddrWidth-1:0] w_row;
    logic                    rd_ok;

    assign nf[i]  = narrow_req_i[i] & narrow_gnt_i[i] & ~rst_i;
    assign n_row  = RowAddrWidth'(narrow_addr_i[i*AddrWidth +: AddrWidth] >> NarrowShift);
    assign w_row  = RowAddrWidth'(wide_addr_i[G*AddrWidth +: AddrWidth] >> WideShift);

    // Narrow takes the bank when both fire; the assertion flags that case.
    assign bank_req_o[i] = nf[i] | wf[G];
    assign bank_we_o[i]  = nf[i] ? narrow_we_i[i] : (wf[G] & wide_we_i[G]);
    assign bank_addr_o[i*RowAddrWidth +: RowAddrWidth] =
      nf[i] ? n_row : (wf[G] ? w_row : '0);
    assign bank_wdata_o[i*DW +: DW] =
      nf[i] ? narrow_wdata_i[i*DW +: DW] : (wf[G] ? wide_wdata_i[i*DW +: DW] : '0);
    assign bank_be_o[i*BW +: BW] =
      nf[i] ? narrow_be_i[i*BW +: BW] : (wf[G] ? wide_be_i[i*BW +: BW] : '0);

    assign tag_in[i] = '{
      valid: nf[i] | wf[G],
      src:   nf[i] ? MEM_SRC_NARROW : MEM_SRC_WIDE,
      we:    bank_we_o[i]
    };

    bank_tag_pipe #(
      .SramLatency(SramLatency)
    ) u_pipe (
      .clk_i(clk_i),
      .rst_i(rst_i),
      .tag_i(tag_in[i]),
      .tag_o(tag_out[i])
    );

    assign n_rvalid_d[i] = tag_out[i].valid & (tag_out[i].src == MEM_SRC_NARROW);
    assign wide_slot[i]  = tag_out[i].valid & (tag_out[i].src == MEM_SRC_WIDE);
    assign rd_ok         = ~tag_out[i].we;

    assign n_rdata_d[i*DW +: DW] =
      (n_rvalid_d[i] & rd_ok) ? bank_rdata_i[i*DW +: DW] : '0;
    assign w_rdata_d[i*DW +: DW] =
      (w_rvalid_d[G] & rd_ok) ? bank_rdata_i[i*DW +: DW] : '0;

    a_excl: assert property (@(posedge clk_i) disable iff (rst_i)
      !(narrow_req_i[i] & narrow_gnt_i[i] & wide_req_i[G] & wide_gnt_i[G]));
  end

`ifdef LAGD_MEM_RSP_REG_EN
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      narrow_rvalid_o <= '0;
      narrow_rdata_o  <= '0;
      wide_rvalid_o   <= '0;
      wide_rdata_o    <= '0;
    end else begin
      narrow_rvalid_o <= n_rvalid_d;
      narrow_rdata_o  <= n_rdata_d;
      wide_rvalid_o   <= w_rvalid_d;
      wide_rdata_o    <= w_rdata_d;
    end
  end
`else
  assign narrow_rvalid_o = n_rvalid_d;
  assign narrow_rdata_o  = n_rdata_d;
  assign wide_rvalid_o   = w_rvalid_d;
  assign wide_rdata_o    = w_rdata_d;
`endif

endmodule

// File: tb/tb_mem_bank_adapter.sv
// Randomized and directed bench for mem_bank_adapter.
// Reference model works on per-cycle fire/rdata history.
module tb_mem_bank_adapter;

  localparam int NNB = 16;
  localparam int NPW = 8;
  localparam int NWB = 2;
  localparam int NDW = 32;
  localparam int WDW = NDW * NPW;
  localparam int AW  = 32;
  localparam int RW  = 10;
  localparam int LAT = 2;
`ifdef LAGD_MEM_RSP_REG_EN
  localparam int RD = 1;
`else
  localparam int RD = 0;
`endif
  localparam int ROWBYTES = 64;

  logic clk = 1'b0;
  logic rst;
  logic [NNB-1:0]       n_req, n_gnt, n_we;
  logic [NNB*AW-1:0]    n_addr;
  logic [NNB*NDW-1:0]   n_wdata;
  logic [NNB*NDW/8-1:0] n_be;
  logic [NWB-1:0]       w_req, w_gnt, w_we;
  logic [NWB*AW-1:0]    w_addr;
  logic [NWB*WDW-1:0]   w_wdata;
  logic [NWB*WDW/8-1:0] w_be;
  logic [NNB-1:0]       bank_req, bank_we;
  logic [NNB*RW-1:0]    bank_addr;
  logic [NNB*NDW-1:0]   bank_wdata;
  logic [NNB*NDW/8-1:0] bank_be;
  logic [NNB*NDW-1:0]   bank_rdata;
  logic [NNB-1:0]       n_rvalid;
  logic [NNB*NDW-1:0]   n_rdata;
  logic [NWB-1:0]       w_rvalid;
  logic [NWB*WDW-1:0]   w_rdata;

  mem_bank_adapter #(
    .NumNarrowBanks(NNB), .NarrowPerWide(NPW), .NarrowDataWidth(NDW),
    .AddrWidth(AW), .RowAddrWidth(RW), .SramLatency(LAT)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .narrow_req_i(n_req), .narrow_gnt_i(n_gnt), .narrow_we_i(n_we),
    .narrow_addr_i(n_addr), .narrow_wdata_i(n_wdata), .narrow_be_i(n_be),
    .wide_req_i(w_req), .wide_gnt_i(w_gnt), .wide_we_i(w_we),
    .wide_addr_i(w_addr), .wide_wdata_i(w_wdata), .wide_be_i(w_be),
    .bank_req_o(bank_req), .bank_we_o(bank_we), .bank_addr_o(bank_addr),
    .bank_wdata_o(bank_wdata), .bank_be_o(bank_be), .bank_rdata_i(bank_rdata),
    .narrow_rvalid_o(n_rvalid), .narrow_rdata_o(n_rdata),
    .wide_rvalid_o(w_rvalid), .wide_rdata_o(w_rdata)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  logic [NNB-1:0]     h_nf  [0:1023];
  logic [NNB-1:0]     h_nwe [0:1023];
  logic [NWB-1:0]     h_wf  [0:1023];
  logic [NWB-1:0]     h_wwe [0:1023];
  logic [NNB*NDW-1:0] h_rd  [0:1023];

  logic [NNB-1:0]       e_req, e_we, e_nrv;
  logic [NNB*RW-1:0]    e_addr;
  logic [NNB*NDW-1:0]   e_wdata, e_nrd;
  logic [NNB*NDW/8-1:0] e_be;
  logic [NWB-1:0]       e_wrv;
  logic [NWB*WDW-1:0]   e_wrd;

  task automatic idle_inputs();
    n_req = '0; n_gnt = '0; n_we = '0; n_addr = '0; n_wdata = '0; n_be = '0;
    w_req = '0; w_gnt = '0; w_we = '0; w_addr = '0; w_wdata = '0; w_be = '0;
  endtask

  task automatic rand_rdata();
    for (int b = 0; b < NNB; b++) bank_rdata[b*NDW +: NDW] = $urandom;
  endtask

  // Records this cycle's activity, then predicts every DUT output.
  task automatic settle();
    int s, r, g, k;
    @(negedge clk);
    h_nf[cyc] = n_req & n_gnt;
    h_nwe[cyc] = n_we;
    h_wf[cyc] = w_req & w_gnt;
    h_wwe[cyc] = w_we;
    h_rd[cyc] = bank_rdata;
    e_req = '0; e_we = '0; e_addr = '0; e_wdata = '0; e_be = '0;
    e_nrv = '0; e_nrd = '0; e_wrv = '0; e_wrd = '0;
    for (int b = 0; b < NNB; b++) begin
      g = b / NPW;
      k = b % NPW;
      if (h_nf[cyc][b]) begin
        e_req[b] = 1'b1;
        e_we[b] = n_we[b];
        e_addr[b*RW +: RW] = RW'((n_addr[b*AW +: AW] / ROWBYTES) % 1024);
        e_wdata[b*NDW +: NDW] = n_wdata[b*NDW +: NDW];
        e_be[b*4 +: 4] = n_be[b*4 +: 4];
      end else if (h_wf[cyc][g]) begin
        e_req[b] = 1'b1;
        e_we[b] = w_we[g];
        e_addr[b*RW +: RW] = RW'((w_addr[g*AW +: AW] / ROWBYTES) % 1024);
        e_wdata[b*NDW +: NDW] = w_wdata[g*WDW + k*NDW +: NDW];
        e_be[b*4 +: 4] = w_be[g*(WDW/8) + k*4 +: 4];
      end
    end
    s = cyc - LAT - RD;
    r = cyc - RD;
    if (s >= 0) begin
      for (int b = 0; b < NNB; b++) begin
        if (h_nf[s][b]) begin
          e_nrv[b] = 1'b1;
          e_nrd[b*NDW +: NDW] = h_nwe[s][b] ? '0 : h_rd[r][b*NDW +: NDW];
        end
      end
      for (int j = 0; j < NWB; j++) begin
        if (h_wf[s][j]) begin
          e_wrv[j] = 1'b1;
          for (int q = 0; q < NPW; q++)
            e_wrd[j*WDW + q*NDW +: NDW] =
              h_wwe[s][j] ? '0 : h_rd[r][(j*NPW+q)*NDW +: NDW];
        end
      end
    end
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    rand_rdata();
    n_req[1] = 1'b1; n_gnt[1] = 1'b1;
    w_req[1] = 1'b1; w_gnt[1] = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    tests++;
    if ({bank_req, bank_we, bank_addr, bank_wdata, bank_be} !== '0) begin
      fails++;
      $display("FAIL reset_bank got %h want 0", {bank_req, bank_we, bank_addr});
    end
    tests++;
    if ({n_rvalid, n_rdata, w_rvalid, w_rdata} !== '0) begin
      fails++;
      $display("FAIL reset_rsp got %h/%h want 0", n_rvalid, w_rvalid);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle_inputs();
    cyc = 0;
  endtask

  task automatic test_narrow_read();
    int c0 = cyc;
    for (int i = 0; i < LAT + RD + 2; i++) begin
      idle_inputs();
      rand_rdata();
      if (i == 0) begin
        n_req[3] = 1'b1; n_gnt[3] = 1'b1;
        n_addr[3*AW +: AW] = 32'h0000_010C;
      end
      settle();
      if (i == 0) begin
        tests++;
        if (bank_addr[3*RW +: RW] !== 10'h004) begin
          fails++;
          $display("FAIL nr_row got %h want 004", bank_addr[3*RW +: RW]);
        end
      end
      if (cyc == c0 + LAT + RD) begin
        tests++;
        if (n_rvalid !== 16'h0008 || n_rdata[3*NDW +: NDW] !== bank_rdata[3*NDW +: NDW]) begin
          fails++;
          $display("FAIL nr_rsp got %h/%h want 0008/%h", n_rvalid,
                   n_rdata[3*NDW +: NDW], bank_rdata[3*NDW +: NDW]);
        end
      end
      tests++;
      if ({bank_req, bank_we, bank_addr, bank_wdata, bank_be} !==
          {e_req, e_we, e_addr, e_wdata, e_be}) begin
        fails++;
        $display("FAIL nr_bank c%0d got %h want %h", cyc,
                 {bank_req, bank_we, bank_addr}, {e_req, e_we, e_addr});
      end
      tests++;
      if ({n_rvalid, n_rdata, w_rvalid, w_rdata} !== {e_nrv, e_nrd, e_wrv, e_wrd}) begin
        fails++;
        $display("FAIL nr_rsp_model c%0d got %h/%h want %h/%h", cyc,
                 n_rvalid, w_rvalid, e_nrv, e_wrv);
      end
      advance();
    end
  endtask

  task automatic test_wide_write();
    int c0 = cyc;
    for (int i = 0; i < LAT + RD + 2; i++) begin
      idle_inputs();
      rand_rdata();
      if (i == 0) begin
        w_req[1] = 1'b1; w_gnt[1] = 1'b1; w_we[1] = 1'b1;
        w_addr[AW +: AW] = $urandom;
        w_be[WDW/8 +: WDW/8] = '1;
        for (int k = 0; k < NPW; k++) w_wdata[WDW + k*NDW +: NDW] = $urandom;
      end
      settle();
      if (i == 0) begin
        tests++;
        if (bank_req !== 16'hFF00 || bank_we !== 16'hFF00 || bank_be[63:32] !== '1) begin
          fails++;
          $display("FAIL ww_banks got %h/%h want ff00/ff00", bank_req, bank_we);
        end
      end
      if (cyc == c0 + LAT + RD) begin
        tests++;
        if (w_rvalid !== 2'b10 || w_rdata[WDW +: WDW] !== '0) begin
          fails++;
          $display("FAIL ww_ack got %b/%h want 10/0", w_rvalid, w_rdata[WDW +: WDW]);
        end
      end
      tests++;
      if ({bank_req, bank_we, bank_addr, bank_wdata, bank_be} !==
          {e_req, e_we, e_addr, e_wdata, e_be}) begin
        fails++;
        $display("FAIL ww_bank c%0d got %h want %h", cyc,
                 {bank_wdata, bank_be}, {e_wdata, e_be});
      end
      tests++;
      if ({w_rvalid, w_rdata, n_rvalid} !== {e_wrv, e_wrd, e_nrv}) begin
        fails++;
        $display("FAIL ww_rsp c%0d got %b want %b", cyc, w_rvalid, e_wrv);
      end
      advance();
    end
  endtask

  task automatic test_wide_read();
    int c0 = cyc;
    int seen = 0;
    logic [WDW-1:0] want;
    for (int k = 0; k < NPW; k++) want[k*NDW +: NDW] = NDW'(k);
    for (int i = 0; i < LAT + RD + 3; i++) begin
      idle_inputs();
      rand_rdata();
      if (i == 0) begin
        w_req[0] = 1'b1; w_gnt[0] = 1'b1;
        w_addr[0 +: AW] = $urandom;
      end
      if (i == LAT)
        for (int k = 0; k < NPW; k++) bank_rdata[k*NDW +: NDW] = NDW'(k);
      settle();
      if (w_rvalid[0]) seen++;
      if (cyc == c0 + LAT + RD) begin
        tests++;
        if (w_rvalid[0] !== 1'b1 || w_rdata[0 +: WDW] !== want) begin
          fails++;
          $display("FAIL wr_merge got %b/%h want 1/%h", w_rvalid[0], w_rdata[0 +: WDW], want);
        end
      end
      tests++;
      if ({w_rvalid, w_rdata, n_rvalid} !== {e_wrv, e_wrd, e_nrv}) begin
        fails++;
        $display("FAIL wr_rsp c%0d got %b want %b", cyc, w_rvalid, e_wrv);
      end
      advance();
    end
    tests++;
    if (seen != 1) begin
      fails++;
      $display("FAIL wr_count got %0d want 1", seen);
    end
  endtask

  task automatic test_back_to_back();
    int c0 = cyc;
    int seen = 0;
    int first = -1;
    for (int i = 0; i < 8 + LAT + RD + 2; i++) begin
      idle_inputs();
      rand_rdata();
      if (i < 8) begin
        n_req[0] = 1'b1; n_gnt[0] = 1'b1;
        n_addr[0 +: AW] = $urandom;
      end
      settle();
      if (n_rvalid[0]) begin
        seen++;
        if (first < 0) first = cyc - c0;
      end
      tests++;
      if ({n_rvalid, n_rdata} !== {e_nrv, e_nrd}) begin
        fails++;
        $display("FAIL b2b_rsp c%0d got %h/%h want %h/%h", cyc,
                 n_rvalid, n_rdata[0 +: NDW], e_nrv, e_nrd[0 +: NDW]);
      end
      advance();
    end
    tests++;
    if (seen != 8 || first != LAT + RD) begin
      fails++;
      $display("FAIL b2b_count got %0d@%0d want 8@%0d", seen, first, LAT + RD);
    end
  endtask

  task automatic test_mid_reset();
    idle_inputs();
    rand_rdata();
    n_req[5] = 1'b1; n_gnt[5] = 1'b1;
    w_req[1] = 1'b1; w_gnt[1] = 1'b1;
    settle();
    advance();
    rst = 1'b1;
    idle_inputs();
    n_req[5] = 1'b1; n_gnt[5] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rand_rdata();
      @(negedge clk);
      tests++;
      if ({bank_req, bank_we, bank_addr, bank_wdata, bank_be,
           n_rvalid, n_rdata, w_rvalid, w_rdata} !== '0) begin
        fails++;
        $display("FAIL mr_during got %h/%h/%h want 0", bank_req, n_rvalid, w_rvalid);
      end
      @(posedge clk);
      #1;
    end
    rst = 1'b0;
    idle_inputs();
    cyc = 0;
    for (int i = 0; i < LAT + RD + 3; i++) begin
      rand_rdata();
      settle();
      tests++;
      if ({bank_req, n_rvalid, n_rdata, w_rvalid, w_rdata} !== '0) begin
        fails++;
        $display("FAIL mr_after c%0d got %h/%h want 0", cyc, n_rvalid, w_rvalid);
      end
      advance();
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      idle_inputs();
      rand_rdata();
      for (int g = 0; g < NWB; g++) begin
        w_req[g] = 1'($urandom & 1);
        w_gnt[g] = ($urandom % 4) != 0;
        w_we[g] = 1'($urandom & 1);
        w_addr[g*AW +: AW] = $urandom;
        w_be[g*(WDW/8) +: WDW/8] = $urandom;
        for (int k = 0; k < NPW; k++) w_wdata[g*WDW + k*NDW +: NDW] = $urandom;
      end
      for (int b = 0; b < NNB; b++) begin
        n_req[b] = 1'($urandom & 1);
        n_gnt[b] = (w_req[b/NPW] & w_gnt[b/NPW]) ? 1'b0 : 1'($urandom & 1);
        n_we[b] = 1'($urandom & 1);
        n_addr[b*AW +: AW] = $urandom;
        n_wdata[b*NDW +: NDW] = $urandom;
        n_be[b*4 +: 4] = 4'($urandom);
      end
      settle();
      tests++;
      if ({bank_req, bank_we, bank_addr, bank_wdata, bank_be} !==
          {e_req, e_we, e_addr, e_wdata, e_be}) begin
        fails++;
        $display("FAIL rnd_bank c%0d got %h want %h", cyc,
                 {bank_req, bank_we, bank_addr}, {e_req, e_we, e_addr});
      end
      tests++;
      if ({n_rvalid, n_rdata} !== {e_nrv, e_nrd}) begin
        fails++;
        $display("FAIL rnd_narrow c%0d got %h want %h", cyc, n_rvalid, e_nrv);
      end
      tests++;
      if ({w_rvalid, w_rdata} !== {e_wrv, e_wrd}) begin
        fails++;
        $display("FAIL rnd_wide c%0d got %b/%h want %b/%h", cyc,
                 w_rvalid, w_rdata[0 +: NDW], e_wrv, e_wrd[0 +: NDW]);
      end
      advance();
    end
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    bank_rdata = '0;
    test_reset();
    test_narrow_read();
    test_wide_write();
    test_wide_read();
    test_back_to_back();
    test_mid_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
